// File: rtl/ps2_command_tx_if.sv
// Command handshake between the game controller and the PS/2 host-to-device transmitter.
interface ps2_command_tx_if;
   logic       send_command;
   logic [7:0] command;
   logic       busy;
   logic       command_sent;
   logic       error;

   modport master (
      output send_command,
      output command,
      input  busy,
      input  command_sent,
      input  error
   );

   modport slave (
      input  send_command,
      input  command,
      output busy,
      output command_sent,
      output error
   );
endinterface

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, device-clocked
// 11-bit frame and acknowledge check, with a timeout on every wait for the device.
module ps2_command_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int RTS_CYCLES     = 500,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic              clock,
   input  logic              reset,
   ps2_command_tx_if.slave   bus,
   inout  wire               PS2_CLK,
   inout  wire               PS2_DAT
);

   localparam int DLY_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int DW      = $clog2(DLY_MAX + 1);
   localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_TX,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE,
      S_ERR
   } state_t;

   state_t          r_state, w_state_next;
   logic [DW-1:0]   r_dly, w_dly_next;
   logic [TW-1:0]   r_timeout, w_timeout_next;
   logic [3:0]      r_bit, w_bit_next;
   logic [8:0]      r_shift, w_shift_next;
   logic            r_dat_low, w_dat_low_next;
   logic [1:0]      r_clk_sync, r_dat_sync;
   logic            r_clk_prev;

   logic            w_clk_s;
   logic            w_dat_s;
   logic            w_fall;
   logic            w_clk_low;
   logic            w_timeout_hit;

   // Synchronizers reset to the idle (pulled-up) level so no false fall appears after reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[0], PS2_CLK};
         r_dat_sync <= {r_dat_sync[0], PS2_DAT};
         r_clk_prev <= r_clk_sync[1];
      end
   end

   assign w_clk_s       = r_clk_sync[1];
   assign w_dat_s       = r_dat_sync[1];
   assign w_fall        = r_clk_prev & ~w_clk_s;
   assign w_timeout_hit = (r_timeout == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_dly     <= '0;
         r_timeout <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_dat_low <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_dly     <= w_dly_next;
         r_timeout <= w_timeout_next;
         r_bit     <= w_bit_next;
         r_shift   <= w_shift_next;
         r_dat_low <= w_dat_low_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_dly_next     = r_dly;
      w_timeout_next = r_timeout;
      w_bit_next     = r_bit;
      w_shift_next   = r_shift;
      w_dat_low_next = r_dat_low;

      case (r_state)
         S_IDLE: begin
            if (bus.send_command) begin
               w_shift_next = {~^bus.command, bus.command};
               w_dly_next   = '0;
               w_bit_next   = '0;
               w_state_next = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (r_dly == DW'(INHIBIT_CYCLES - 1)) begin
               w_dly_next     = '0;
               w_dat_low_next = 1'b1;
               w_state_next   = S_RTS;
            end else begin
               w_dly_next = r_dly + DW'(1);
            end
         end
         S_RTS: begin
            if (r_dly == DW'(RTS_CYCLES - 1)) begin
               w_dly_next     = '0;
               w_timeout_next = '0;
               w_state_next   = S_TX;
            end else begin
               w_dly_next = r_dly + DW'(1);
            end
         end
         S_TX: begin
            // A fall outranks a timeout landing on the same cycle
            if (w_fall) begin
               w_timeout_next = '0;
               w_bit_next     = r_bit + 4'd1;
               if (r_bit == 4'd9) begin
                  w_dat_low_next = 1'b0;
                  w_state_next   = S_ACK;
               end else begin
                  w_dat_low_next = ~r_shift[0];
                  w_shift_next   = {1'b0, r_shift[8:1]};
               end
            end else if (w_timeout_hit) begin
               w_dat_low_next = 1'b0;
               w_state_next   = S_ERR;
            end else begin
               w_timeout_next = r_timeout + TW'(1);
            end
         end
         S_ACK: begin
            if (w_fall) begin
               w_timeout_next = '0;
               w_state_next   = w_dat_s ? S_ERR : S_WAIT_IDLE;
            end else if (w_timeout_hit) begin
               w_state_next = S_ERR;
            end else begin
               w_timeout_next = r_timeout + TW'(1);
            end
         end
         S_WAIT_IDLE: begin
            if (w_clk_s && w_dat_s) begin
               w_state_next = S_DONE;
            end else if (w_fall) begin
               w_timeout_next = '0;
            end else if (w_timeout_hit) begin
               w_state_next = S_ERR;
            end else begin
               w_timeout_next = r_timeout + TW'(1);
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         S_ERR: begin
            w_dat_low_next = 1'b0;
            w_state_next   = S_IDLE;
         end
         default: begin
            w_dat_low_next = 1'b0;
            w_state_next   = S_IDLE;
         end
      endcase
   end

   // Open-drain pins: only ever pulled low or released
   assign w_clk_low = (r_state == S_INHIBIT) || (r_state == S_RTS);
   assign PS2_CLK   = w_clk_low ? 1'b0 : 1'bz;
   assign PS2_DAT   = r_dat_low ? 1'b0 : 1'bz;

   assign bus.busy         = (r_state != S_IDLE);
   assign bus.command_sent = (r_state == S_DONE);
   assign bus.error        = (r_state == S_ERR);

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench: pulled-up PS/2 lines with a device model clocking at a 20-cycle period.
module tb_ps2_command_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   wire  ps2_clk;
   wire  ps2_dat;
   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;

   pullup (ps2_clk);
   pullup (ps2_dat);
   assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

   ps2_command_tx_if bus ();

   ps2_command_tx #(
      .INHIBIT_CYCLES (8),
      .RTS_CYCLES     (4),
      .TIMEOUT_CYCLES (200)
   ) dut (
      .clock   (clk),
      .reset   (rst),
      .bus     (bus),
      .PS2_CLK (ps2_clk),
      .PS2_DAT (ps2_dat)
   );

   int total = 0;
   int bad   = 0;
   int n_sent = 0;
   int n_err  = 0;
   bit both_seen = 1'b0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.command_sent === 1'b1) n_sent++;
      if (bus.error === 1'b1) n_err++;
      if (bus.command_sent === 1'b1 && bus.error === 1'b1) both_seen = 1'b1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Request a frame and check the inhibit / request-to-send phases cycle by cycle
   task automatic start_frame(input logic [7:0] cmd, input bit pulse_again);
      @(negedge clk);
      bus.command      = cmd;
      bus.send_command = 1'b1;
      @(negedge clk);
      bus.send_command = 1'b0;
      check("busy_on", 32'(bus.busy), 1);
      check("inh_clk", 32'(ps2_clk), 0);
      check("inh_dat", 32'(ps2_dat), 1);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus.command      = 8'hAA;
            bus.send_command = pulse_again;
         end
         if (i == 2) bus.send_command = 1'b0;
         if (i == 7) check("inh_dat_end", 32'(ps2_dat), 1);
         if (i == 8) begin
            check("rts_dat", 32'(ps2_dat), 0);
            check("rts_clk", 32'(ps2_clk), 0);
         end
         if (i == 11) check("rts_clk_end", 32'(ps2_clk), 0);
         if (i == 12) begin
            check("tx_clk_released", 32'(ps2_clk), 1);
            check("tx_start_bit", 32'(ps2_dat), 0);
         end
      end
   endtask

   // Device model: samples start bit, then n_pulses clocks sampling on each rising edge
   task automatic device_frame(input int n_pulses, input bit do_ack, output logic [10:0] got);
      got    = '1;
      got[0] = ps2_dat;
      for (int k = 1; k <= n_pulses; k++) begin
         repeat (5) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (10) @(negedge clk);
         got[k]      = ps2_dat;
         dev_clk_low = 1'b0;
         repeat (5) @(negedge clk);
      end
      if (n_pulses == 10) begin
         repeat (2) @(negedge clk);
         if (do_ack) dev_dat_low = 1'b1;
         repeat (3) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (10) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (5) @(negedge clk);
         dev_dat_low = 1'b0;
      end
   endtask

   task automatic wait_not_busy(input string tag);
      int k;
      k = 0;
      while (bus.busy !== 1'b0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(bus.busy), 0);
   endtask

   initial begin
      logic [10:0] got;
      int s0;
      int e0;
      int k;
      bit idle_bad;

      bus.send_command = 1'b0;
      bus.command      = 8'h00;
      idle_bad         = 1'b0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_sent", 32'(bus.command_sent), 0);
      check("rst_err", 32'(bus.error), 0);
      check("rst_clk", 32'(ps2_clk), 1);
      check("rst_dat", 32'(ps2_dat), 1);
      rst = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || bus.busy !== 1'b0) idle_bad = 1'b1;
      end
      check("idle_quiet", 32'(idle_bad), 0);
      check("idle_pulses", n_sent + n_err, 0);

      // 0xF4: frame {stop=1, parity=0, F4, start=0}
      s0 = n_sent; e0 = n_err;
      start_frame(8'hF4, 1'b0);
      device_frame(10, 1'b1, got);
      wait_not_busy("f4_busy_drop");
      check("f4_frame", 32'(got), 32'h5E8);
      check("f4_sent", n_sent - s0, 1);
      check("f4_err", n_err - e0, 0);

      s0 = n_sent; e0 = n_err;
      start_frame(8'h00, 1'b0);
      device_frame(10, 1'b1, got);
      wait_not_busy("z00_busy_drop");
      check("z00_frame", 32'(got), 32'h600);
      check("z00_sent", n_sent - s0, 1);
      check("z00_err", n_err - e0, 0);

      s0 = n_sent; e0 = n_err;
      start_frame(8'hFF, 1'b0);
      device_frame(10, 1'b1, got);
      wait_not_busy("ff_busy_drop");
      check("ff_frame", 32'(got), 32'h7FE);
      check("ff_sent", n_sent - s0, 1);
      check("ff_err", n_err - e0, 0);

      // Device never clocks: error exactly 200 cycles after clock release
      s0 = n_sent; e0 = n_err;
      start_frame(8'h3C, 1'b0);
      k = 0;
      while (bus.error !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("to_latency", k, 200);
      check("to_clk_rel", 32'(ps2_clk), 1);
      check("to_dat_rel", 32'(ps2_dat), 1);
      wait_not_busy("to_busy_drop");
      check("to_err", n_err - e0, 1);
      check("to_sent", n_sent - s0, 0);

      // Missing acknowledge
      s0 = n_sent; e0 = n_err;
      start_frame(8'hF4, 1'b0);
      device_frame(10, 1'b0, got);
      wait_not_busy("nack_busy_drop");
      check("nack_frame", 32'(got), 32'h5E8);
      check("nack_err", n_err - e0, 1);
      check("nack_sent", n_sent - s0, 0);

      // Reset while data bit 3 (a 0 for F4) is being driven
      s0 = n_sent; e0 = n_err;
      start_frame(8'hF4, 1'b0);
      device_frame(4, 1'b1, got);
      check("mid_bits", 32'(got[4:0]), 32'h08);
      check("mid_bit3_driven", 32'(ps2_dat), 0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_dat", 32'(ps2_dat), 1);
      check("mid_rst_clk", 32'(ps2_clk), 1);
      check("mid_rst_busy", 32'(bus.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_no_pulse", (n_sent - s0) + (n_err - e0), 0);
      start_frame(8'hFF, 1'b0);
      device_frame(10, 1'b1, got);
      wait_not_busy("post_rst_busy_drop");
      check("post_rst_frame", 32'(got), 32'h7FE);
      check("post_rst_sent", n_sent - s0, 1);

      // Second request with 0xAA while busy is ignored
      s0 = n_sent; e0 = n_err;
      start_frame(8'hF4, 1'b1);
      device_frame(10, 1'b1, got);
      wait_not_busy("ign_busy_drop");
      check("ign_frame", 32'(got), 32'h5E8);
      repeat (30) @(negedge clk);
      check("ign_still_idle", 32'(bus.busy), 0);
      check("ign_sent", n_sent - s0, 1);
      check("ign_err", n_err - e0, 0);

      check("never_both", 32'(both_seen), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
